alu_pipe_mc: RTL and testbench
==============================

// Module: alu_pipe_mc
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle execute ALU.
//  Accepts one operation per valid/ready transfer and returns a registered result.
//  Adds signed saturation, lane-parametrised PADDSB and an iterative shift-add MUL.
//  Sits between decode/regfile read and writeback; stalls upstream via in_ready.
// PARAMETERS
//  WIDTH  16  datapath width in bits; >=8, power of two
//  LANE   4   PADDSB lane width; must divide WIDTH
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      opcode/operands valid
//  in_ready   out  1      block can accept an operation this cycle
//  opcode     in   4      operation select
//  operand1   in   WIDTH  A operand
//  operand2   in   WIDTH  B operand; shift amount = operand2[$clog2(WIDTH)-1:0]
//  out_valid  out  1      result/err valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  err        out  1      accepted opcode was illegal
//  flags      out  3      {V,N,Z} flag register
//  busy       out  1      high in MUL state
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, err=0, flags=3'b000, busy=0; MUL counter cleared.
//  FSM: IDLE --accept, op!=MUL--> DONE
//       IDLE --accept, MUL--> MUL
//       MUL --count==WIDTH-1--> DONE
//       DONE --out_ready & !accept--> IDLE
//       DONE --out_ready & accept--> DONE or MUL
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  Latency: single-cycle op accepted at edge N -> out_valid high after edge N+1.
//  Latency: MUL -> out_valid high after edge N+WIDTH+1.
//  Back-to-back: one result per cycle when out_ready held high for single-cycle ops.
//  Operands and opcode are captured at accept; input changes after accept are ignored.
//  DONE: result, err and out_valid stay stable until out_ready.
//  Ops (signed two's complement; unlisted ops have no flag update):
//   0000 ADD: A+B, saturate to 0x7F..F / 0x80..0; V=saturated; updates V,N,Z.
//   0001 SUB: A-B, same saturation rule; updates V,N,Z.
//   0010 XOR; 0011 AND: update Z only.
//   0100 SLL: zero fill; updates Z.
//   0101 SRA: sign fill; updates Z.
//   0110 ROR: rotate right; updates Z.
//   0111 PADDSB: per-LANE signed add, each lane saturates independently; no carry between lanes.
//   1000 MUL: low WIDTH bits of A*B via shift-add, one partial product per cycle.
//        Updates N,Z; V=0.
//   other: result=0, err=1, flags unchanged.
//  Flag timing: the flag register loads on the same edge the result enters DONE.
//  Flag timing: new flags are visible together with out_valid.
//  Shift amount 0 returns A unchanged; ROR by 0 returns A.
//  rst in any state, including mid-MUL or DONE with out_ready low:
//   abort, discard result, return to reset values next edge.
//  in_valid while busy or while DONE without out_ready: not accepted (in_ready=0).
// TESTING
//  ADD 0x7FFF+0x0001 -> result 0x7FFF, flags V=1 N=0 Z=0, out_valid 1 cycle after accept.
//  SUB 0x0005-0x0005 -> 0x0000, Z=1; then XOR 0x00F0^0x00F0 -> 0x0000, Z=1, V,N retained.
//  PADDSB 0x7878+0x1111 (LANE=4) -> 0x7979.
//  MUL 0x0003*0xFFFF -> 0xFFFD, N=1, busy for 16 cycles, out_valid exactly 17 cycles after accept.
//  Backpressure: out_ready low 3 cycles in DONE -> result stable, in_ready=0.
//  Backpressure: raise out_ready with in_valid high -> next op accepted same cycle.
//  Illegal opcode 0x9 -> result 0, err=1, flags unchanged.
//  rst asserted at cycle 8 of MUL -> out_valid never rises, flags 000, in_ready=1 after reset.

Source files
------------

// File: rtl/alu_pipe_mc.sv
// Handshaked execute ALU: one operation per valid/ready transfer, registered result,
// signed saturating ADD/SUB, lane-wise saturating PADDSB and an iterative shift-add MUL.
module alu_pipe_mc #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam int NL  = WIDTH / LANE;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};
  localparam logic [3:0]       OP_MUL = 4'h8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_result, r_mcand, r_mplier, r_acc;
  logic             r_err;
  logic [2:0]       r_flags;
  logic [SHW-1:0]   r_cnt;

  logic             w_accept, w_mul_last, w_err, w_vsat;
  logic [1:0]       w_fmode;
  logic [2:0]       w_flags;
  logic [WIDTH-1:0] w_res, w_padd, w_acc_next;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [LANE:0]    w_lane;
  logic [2*WIDTH-1:0] w_rot;
  logic [SHW-1:0]   w_sh;

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // out_valid is held with result/err/flags frozen until out_ready is seen high.
  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_MUL);
  assign result     = r_result;
  assign err        = r_err;
  assign flags      = r_flags;
  assign dbg_state  = r_state;
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign w_sh  = operand2[SHW-1:0];
  assign w_sum = {operand1[WIDTH-1], operand1} + {operand2[WIDTH-1], operand2};
  assign w_dif = {operand1[WIDTH-1], operand1} - {operand2[WIDTH-1], operand2};
  assign w_rot = {operand1, operand1} >> w_sh;

  always_comb begin
    w_padd = '0;
    w_lane = '0;
    for (int l = 0; l < NL; l++) begin
      w_lane = {operand1[l*LANE+LANE-1], operand1[l*LANE +: LANE]} +
               {operand2[l*LANE+LANE-1], operand2[l*LANE +: LANE]};
      if (w_lane[LANE] != w_lane[LANE-1]) w_padd[l*LANE +: LANE] = w_lane[LANE] ? LMIN : LMAX;
      else                                w_padd[l*LANE +: LANE] = w_lane[LANE-1:0];
    end
  end

  // w_fmode: 0 keeps flags, 1 loads V,N,Z, 2 loads Z only
  always_comb begin
    w_res   = '0;
    w_err   = 1'b0;
    w_vsat  = 1'b0;
    w_fmode = 2'd0;
    case (opcode)
      4'h0: begin
        w_vsat  = (w_sum[WIDTH] != w_sum[WIDTH-1]);
        w_res   = w_vsat ? (w_sum[WIDTH] ? MINV : MAXV) : w_sum[WIDTH-1:0];
        w_fmode = 2'd1;
      end
      4'h1: begin
        w_vsat  = (w_dif[WIDTH] != w_dif[WIDTH-1]);
        w_res   = w_vsat ? (w_dif[WIDTH] ? MINV : MAXV) : w_dif[WIDTH-1:0];
        w_fmode = 2'd1;
      end
      4'h2: begin w_res = operand1 ^ operand2;           w_fmode = 2'd2; end
      4'h3: begin w_res = operand1 & operand2;           w_fmode = 2'd2; end
      4'h4: begin w_res = operand1 << w_sh;              w_fmode = 2'd2; end
      4'h5: begin w_res = $signed(operand1) >>> w_sh;    w_fmode = 2'd2; end
      4'h6: begin w_res = w_rot[WIDTH-1:0];              w_fmode = 2'd2; end
      4'h7: w_res = w_padd;
      OP_MUL: w_res = '0;
      default: w_err = 1'b1;
    endcase
    w_flags = r_flags;
    if (w_fmode == 2'd1)      w_flags = {w_vsat, w_res[WIDTH-1], (w_res == '0)};
    else if (w_fmode == 2'd2) w_flags[0] = (w_res == '0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = (opcode == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = w_accept ? ((opcode == OP_MUL) ? S_MUL : S_DONE) : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_err    <= 1'b0;
      r_flags  <= 3'b000;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (opcode == OP_MUL) begin
          r_mcand  <= operand1;
          r_mplier <= operand2;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_result <= w_res;
          r_err    <= w_err;
          r_flags  <= w_flags;
        end
      end else if (r_state == S_MUL) begin
        // one partial product per cycle; the last one goes straight to the result
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_result <= w_acc_next;
          r_err    <= 1'b0;
          r_flags  <= {1'b0, w_acc_next[WIDTH-1], (w_acc_next == '0)};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_mc.sv
// Bench for alu_pipe_mc: directed spot checks plus randomized traffic scored
// against an arithmetic reference model through an expected-response queue.
module tb_alu_pipe_mc;
  localparam int W    = 16;
  localparam int LANE = 4;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [3:0]    opcode;
  logic [W-1:0]  operand1, operand2, result;
  logic [2:0]    flags;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [2:0]   m_flags = 3'b000;
  logic [W+3:0] exp_q[$];
  bit           rand_ready = 0;

  alu_pipe_mc #(.WIDTH(W), .LANE(LANE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .err(err), .flags(flags), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // reference model: plain integer arithmetic over the operation rules
  function automatic int clamp(input int v, input int lo, input int hi, output bit sat);
    sat = 1'b0;
    if (v > hi) begin sat = 1'b1; return hi; end
    if (v < lo) begin sat = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic e);
    int sa, sb, s, sh, la, lb;
    bit v;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    sh = b % W;
    res = '0;
    e = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sa + sb : sa - sb;
        s = clamp(s, -(2 ** (W - 1)), 2 ** (W - 1) - 1, v);
        res = s[W-1:0];
        m_flags = {v, res[W-1], res == 0};
      end
      4'h2: begin res = a ^ b; m_flags[0] = (res == 0); end
      4'h3: begin res = a & b; m_flags[0] = (res == 0); end
      4'h4: begin res = W'(a << sh); m_flags[0] = (res == 0); end
      4'h5: begin s = sa >>> sh; res = s[W-1:0]; m_flags[0] = (res == 0); end
      4'h6: begin
        for (int k = 0; k < W; k++) res[k] = a[(k + sh) % W];
        m_flags[0] = (res == 0);
      end
      4'h7: begin
        for (int l = 0; l < W / LANE; l++) begin
          la = a[l*LANE +: LANE];
          lb = b[l*LANE +: LANE];
          if (la >= 2 ** (LANE - 1)) la -= 2 ** LANE;
          if (lb >= 2 ** (LANE - 1)) lb -= 2 ** LANE;
          s = clamp(la + lb, -(2 ** (LANE - 1)), 2 ** (LANE - 1) - 1, v);
          res[l*LANE +: LANE] = s[LANE-1:0];
        end
      end
      4'h8: begin
        p = longint'(a) * longint'(b);
        res = p[W-1:0];
        m_flags = {1'b0, res[W-1], res == 0};
      end
      default: begin res = '0; e = 1'b1; end
    endcase
  endtask

  // driver: present an op from posedge+1, wait for in_ready, push expectation, scramble inputs after accept
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    logic [W-1:0] r;
    logic e;
    waited = 0;
    in_valid = 1'b1;
    opcode = op;
    operand1 = a;
    operand2 = b;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) fail_now("issue_timeout");
    else begin
      model(op, a, b, r, e);
      exp_q.push_back({r, e, m_flags});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = 4'($urandom);
    operand1 = W'($urandom);
    operand2 = W'($urandom);
  endtask

  // directed: check output on the first negedge after accept
  task automatic expect_next(input string name, input logic [W-1:0] r, input logic e, input logic [2:0] f);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_out"}, {result, err, flags}, {r, e, f});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [W+3:0] act, held, expv;
    bit stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 0;
      else if (out_valid) begin
        act = {result, err, flags};
        if (stalled) check("hold_stable", act, held);
        if (out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else begin
            expv = exp_q.pop_front();
            check("scoreboard", act, expv);
          end
          stalled = 0;
        end else begin
          held = act;
          stalled = 1;
        end
      end else begin
        if (stalled) fail_now("valid_dropped");
        stalled = 0;
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : stim
    int w, tot, cyc, bcnt, vcnt;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [W-1:0] corners [5];
    corners[0] = 16'h7FFF; corners[1] = 16'h8000; corners[2] = 16'hFFFF;
    corners[3] = 16'h0000; corners[4] = 16'h0001;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    issue(4'h0, 16'h7FFF, 16'h0001, w); expect_next("add_sat", 16'h7FFF, 0, 3'b100);
    issue(4'h2, 16'h00F0, 16'h00F0, w); expect_next("xor_keep_v", 16'h0000, 0, 3'b101);
    issue(4'h1, 16'h0005, 16'h0005, w); expect_next("sub_zero", 16'h0000, 0, 3'b001);
    issue(4'h2, 16'h00F0, 16'h00F0, w); expect_next("xor_zero", 16'h0000, 0, 3'b001);
    issue(4'h7, 16'h7878, 16'h1111, w); expect_next("paddsb", 16'h7979, 0, 3'b001);
    issue(4'h4, 16'h1234, 16'h0000, w); expect_next("sll0", 16'h1234, 0, 3'b000);
    issue(4'h6, 16'h00F1, 16'h0004, w); expect_next("ror4", 16'h100F, 0, 3'b000);
    issue(4'h5, 16'h8000, 16'h000F, w); expect_next("sra15", 16'hFFFF, 0, 3'b000);
    issue(4'h1, 16'h8000, 16'h0001, w); expect_next("sub_sat", 16'h8000, 0, 3'b110);

    issue(4'h8, 16'h0003, 16'hFFFF, w);
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end while (!out_valid && cyc < 40);
    check("mul_latency", cyc, 17);
    check("mul_busy_cycles", bcnt, 16);
    check("mul_out", {result, err, flags}, {16'hFFFD, 1'b0, 3'b010});
    @(posedge clk);
    #1;

    issue(4'h9, 16'h1234, 16'h5678, w); expect_next("illegal", 16'h0000, 1, 3'b010);

    // backpressure then release with a new op waiting
    out_ready = 1'b0;
    issue(4'h0, 16'h0001, 16'h0002, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", {out_valid, result}, {1'b1, 16'h0003});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(4'h4, 16'h0001, 16'h0004, w);
    check("bp_release_accept_wait", w, 0);
    expect_next("bp_next", 16'h0010, 0, 3'b000);

    tot = 0;
    for (int k = 0; k < 6; k++) begin
      issue(4'($urandom_range(0, 7)), W'($urandom), W'($urandom), w);
      tot += w;
    end
    check("back_to_back_wait", tot, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a MUL
    issue(4'h8, 16'h1234, 16'h0F0F, w);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_flags = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("abort_no_valid", vcnt, 0);
    check("abort_flags", flags, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #1;

    rand_ready = 1;
    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 19) < 16) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      issue(op, a, b, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    rand_ready = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
